regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file for the multicycle processor datapath.
- Generalises the fixed 8-entry, 2-read/1-write file with link-register write to configurable width and depth.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard, so the control FSM can detect reads of registers with an outstanding write.
- Sits between decode/control and the ALU operand muxes.

Parameters:
W, 32, data width of each register
DEPTH, 8, number of registers (2 to 2**AW)
AW, 3, address width
LR_IDX, 7, index written by the link-register port
BYPASS, 1, 1 = read ports see same-cycle write data; 0 = read stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
we  in  1  general write enable
wa  in  AW  general write address
wd  in  W  general write data
lr_we  in  1  link-register write enable
lr_wd  in  W  link-register write data
claim_en  in  1  mark register claim_addr busy (pending write)
claim_addr  in  AW  register to mark busy
ra1  in  AW  read address port 1
ra2  in  AW  read address port 2
rd1  out  W  read data port 1
rd2  out  W  read data port 2
busy1  out  1  register at ra1 has a pending write
busy2  out  1  register at ra2 has a pending write
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (reset==0 at a rising edge):
  - All DEPTH registers <= 0; all busy bits <= 0; busy_cnt = 0.
  - Overrides all writes and claims that cycle.
- Reads are combinational, zero latency.
  - After reset, rd1/rd2 = 0 and busy1/busy2 = 0.
- General write: we==1 -> reg[wa] <= wd at the edge; busy[wa] <= 0.
- LR write: lr_we==1 -> reg[LR_IDX] <= lr_wd; busy[LR_IDX] <= 0.
- Write conflict: we and lr_we in the same cycle with wa==LR_IDX -> general port wins, lr_wd is discarded. Otherwise both writes commit in the same cycle.
- Claim: claim_en==1 -> busy[claim_addr] <= 1.
  - A claim and a write (either port) to the same register in the same cycle -> data is written and busy ends at 1 (claim wins; it names the new producer).
  - Claiming an already-busy register leaves it busy; no error is flagged.
- Address range:
  - Reads with ra >= DEPTH return 0 with busy=0.
  - Writes and claims with address >= DEPTH are ignored.
- Bypass (BYPASS=1), evaluated per read port:
  - ra==wa and we -> data = wd.
  - Else ra==LR_IDX and lr_we -> data = lr_wd.
  - Else data = stored value.
  - busy reflects the post-write state: a register being written this cycle reads busy=0, unless it is also claimed this cycle, in which case busy=1.
- No bypass (BYPASS=0): read ports show stored value and stored busy bit only; new values are visible the cycle after the edge.
- busy_cnt = popcount of busy bits, registered (updated at the same edge as the busy bits). Range 0..DEPTH.
- Both read ports may address the same register; they return identical values.

Test Plan:
(W=32, DEPTH=8, LR_IDX=7, BYPASS=1 unless stated)
- Reset:
  - Stimulus: preload r3=0xDEADBEEF and mark r3 busy, then hold reset=0 for one edge.
  - Required: rd1(ra1=3)=0, busy1=0, busy_cnt=0.
- Write/read:
  - Stimulus: we=1, wa=2, wd=0x12345678; next cycle ra1=2, ra2=5.
  - Required: rd1=0x12345678, rd2=0.
  - Same-cycle bypass: with ra1=2 during the write, rd1=0x12345678 already that cycle.
  - With BYPASS=0: rd1 shows the old value (0) until the following cycle.
- LR conflict:
  - Stimulus: we=1, wa=7, wd=0xAAAA0000 and lr_we=1, lr_wd=0x00000044 in the same cycle.
  - Required: next cycle rd1(ra1=7)=0xAAAA0000.
  - Stimulus: lr_we only, lr_wd=0x44. Required: rd1=0x44.
- Scoreboard:
  - Stimulus: claim r4, then claim r5.
  - Required: busy_cnt=1, then 2; busy1(ra1=4)=1.
  - Stimulus: write r4=0x99. Required: same-cycle busy1=0 and rd1=0x99 (bypass); busy_cnt=1 next cycle.
- Claim+write collision:
  - Stimulus: claim_en=1, claim_addr=3 together with we=1, wa=3, wd=0x55.
  - Required: next cycle rd1(ra1=3)=0x55, busy1=1.
- Out-of-range (DEPTH=6, AW=3):
  - Stimulus: we=1, wa=6, wd=0x77, and claim_en=1, claim_addr=7.
  - Required: rd1(ra1=6)=0, busy1=0, busy_cnt unchanged.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with link-register write port, optional write-to-read bypass,
// and a per-register busy scoreboard for tracking outstanding writes.
module regfile_scoreboard #(
  parameter int unsigned W      = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned LR_IDX = 7,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          lr_we,
  input  logic [W-1:0]  lr_wd,
  input  logic          claim_en,
  input  logic [AW-1:0] claim_addr,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt
);

  logic [W-1:0]     regs_q [DEPTH];
  logic [W-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  // Per-entry decode: out-of-range addresses simply match no entry.
  // Ordering gives the general port priority over LR, and a claim priority over both writes.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (lr_we && (int'(LR_IDX) == i)) begin
        regs_d[i] = lr_wd;
        busy_d[i] = 1'b0;
      end
      if (we && (wa == AW'(i))) begin
        regs_d[i] = wd;
        busy_d[i] = 1'b0;
      end
      if (claim_en && (claim_addr == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  // With bypass, the next-state view is exactly the post-write data and busy state.
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ra1 == AW'(i)) begin
        rd1   = BYPASS ? regs_d[i] : regs_q[i];
        busy1 = BYPASS ? busy_d[i] : busy_q[i];
      end
      if (ra2 == AW'(i)) begin
        rd2   = BYPASS ? regs_d[i] : regs_q[i];
        busy2 = BYPASS ? busy_d[i] : busy_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, no-bypass and DEPTH=6 instances share stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, lr_we, claim_en;
  logic [2:0]  wa, claim_addr, ra1, ra2;
  logic [31:0] wd, lr_wd;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
  logic        busy1_a, busy2_a, busy1_b, busy2_b, busy1_c, busy2_c;
  logic [3:0]  cnt_a, cnt_b, cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.W(32), .DEPTH(8), .AW(3), .LR_IDX(7), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .lr_we(lr_we), .lr_wd(lr_wd),
    .claim_en(claim_en), .claim_addr(claim_addr), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_a), .rd2(rd2_a), .busy1(busy1_a), .busy2(busy2_a), .busy_cnt(cnt_a)
  );

  regfile_scoreboard #(.W(32), .DEPTH(8), .AW(3), .LR_IDX(7), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .lr_we(lr_we), .lr_wd(lr_wd),
    .claim_en(claim_en), .claim_addr(claim_addr), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_b), .rd2(rd2_b), .busy1(busy1_b), .busy2(busy2_b), .busy_cnt(cnt_b)
  );

  regfile_scoreboard #(.W(32), .DEPTH(6), .AW(3), .LR_IDX(7), .BYPASS(1'b1)) u_c (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .lr_we(lr_we), .lr_wd(lr_wd),
    .claim_en(claim_en), .claim_addr(claim_addr), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_c), .rd2(rd2_c), .busy1(busy1_c), .busy2(busy2_c), .busy_cnt(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; lr_we = 1'b0; lr_wd = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  initial begin
    idle();
    ra1 = '0; ra2 = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Preload r3 and mark it busy, then reset
    we = 1'b1; wa = 3'd3; wd = 32'hDEADBEEF;
    tick();
    idle(); claim_en = 1'b1; claim_addr = 3'd3;
    tick();
    idle(); ra1 = 3'd3; ra2 = 3'd3;
    #1;
    check("preload_rd1", rd1_a, 32'hDEADBEEF);
    check("preload_busy1", {31'd0, busy1_a}, 32'd1);
    check("preload_cnt", {28'd0, cnt_a}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("reset_rd1", rd1_a, 32'd0);
    check("reset_busy1", {31'd0, busy1_a}, 32'd0);
    check("reset_busy2", {31'd0, busy2_a}, 32'd0);
    check("reset_cnt", {28'd0, cnt_a}, 32'd0);

    // Write r2 with same-cycle read
    we = 1'b1; wa = 3'd2; wd = 32'h12345678; ra1 = 3'd2; ra2 = 3'd5;
    #1;
    check("bypass_rd1", rd1_a, 32'h12345678);
    check("nobypass_rd1_old", rd1_b, 32'd0);
    tick();
    idle();
    #1;
    check("write_rd1", rd1_a, 32'h12345678);
    check("write_rd2", rd2_a, 32'd0);
    check("nobypass_rd1_new", rd1_b, 32'h12345678);

    // General port beats LR on a conflict
    we = 1'b1; wa = 3'd7; wd = 32'hAAAA0000; lr_we = 1'b1; lr_wd = 32'h44; ra1 = 3'd7;
    #1;
    check("conflict_bypass", rd1_a, 32'hAAAA0000);
    tick();
    idle();
    #1;
    check("conflict_rd1", rd1_a, 32'hAAAA0000);
    check("conflict_rd1_nb", rd1_b, 32'hAAAA0000);
    lr_we = 1'b1; lr_wd = 32'h44;
    #1;
    check("lr_bypass", rd1_a, 32'h44);
    check("lr_nobypass_old", rd1_b, 32'hAAAA0000);
    tick();
    idle();
    #1;
    check("lr_rd1", rd1_a, 32'h44);

    // Non-conflicting general and LR writes both commit
    we = 1'b1; wa = 3'd1; wd = 32'h11; lr_we = 1'b1; lr_wd = 32'h22;
    tick();
    idle(); ra1 = 3'd1; ra2 = 3'd7;
    #1;
    check("dual_rd1", rd1_a, 32'h11);
    check("dual_rd2", rd2_a, 32'h22);
    ra2 = 3'd1;
    #1;
    check("same_addr_rd2", rd2_a, 32'h11);

    // Scoreboard claims
    claim_en = 1'b1; claim_addr = 3'd4; ra1 = 3'd4;
    #1;
    check("claim_bypass_busy", {31'd0, busy1_a}, 32'd1);
    check("claim_nobypass_busy", {31'd0, busy1_b}, 32'd0);
    tick();
    check("claim4_cnt", {28'd0, cnt_a}, 32'd1);
    claim_addr = 3'd5;
    tick();
    idle();
    #1;
    check("claim5_cnt", {28'd0, cnt_a}, 32'd2);
    check("claim4_busy1", {31'd0, busy1_a}, 32'd1);
    we = 1'b1; wa = 3'd4; wd = 32'h99;
    #1;
    check("wr4_busy1", {31'd0, busy1_a}, 32'd0);
    check("wr4_rd1", rd1_a, 32'h99);
    check("wr4_cnt_before", {28'd0, cnt_a}, 32'd2);
    tick();
    idle();
    #1;
    check("wr4_cnt_after", {28'd0, cnt_a}, 32'd1);

    // Claim and write to the same register in one cycle
    claim_en = 1'b1; claim_addr = 3'd3; we = 1'b1; wa = 3'd3; wd = 32'h55;
    tick();
    idle(); ra1 = 3'd3;
    #1;
    check("collide_rd1", rd1_a, 32'h55);
    check("collide_busy1", {31'd0, busy1_a}, 32'd1);
    check("collide_cnt", {28'd0, cnt_a}, 32'd2);

    // Re-claiming a busy register keeps the count
    claim_en = 1'b1; claim_addr = 3'd5;
    tick();
    idle();
    #1;
    check("reclaim_cnt", {28'd0, cnt_a}, 32'd2);

    // Out-of-range write and claim on the DEPTH=6 instance
    check("oor_cnt_before", {28'd0, cnt_c}, 32'd2);
    we = 1'b1; wa = 3'd6; wd = 32'h77; claim_en = 1'b1; claim_addr = 3'd7; ra1 = 3'd6;
    #1;
    check("oor_bypass_rd1", rd1_c, 32'd0);
    tick();
    idle(); ra2 = 3'd7;
    #1;
    check("oor_rd1", rd1_c, 32'd0);
    check("oor_busy1", {31'd0, busy1_c}, 32'd0);
    check("oor_busy2", {31'd0, busy2_c}, 32'd0);
    check("oor_cnt", {28'd0, cnt_c}, 32'd2);
    check("inrange_rd1", rd1_a, 32'h77);
    check("inrange_cnt", {28'd0, cnt_a}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
